// File: rtl/play_pkg.sv
// Shared definitions for the play scheduler: state encoding, requester count
// and default timing parameters.
package play_pkg;

  localparam int N_REQ        = 4;
  localparam int DEF_BEAT_LEN = 4;
  localparam int DEF_GAP_CYC  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_PLAY  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb4.sv
// Combinational round-robin pick over four requesters, scanning upward from
// the requester after the last owner.
module rr_arb4
  import play_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       idx,
  output logic             valid
);

  logic [1:0] cand_s;
  logic       hit_s;

  // First asserted request at or after last+1 (mod 4) wins
  always_comb begin
    gnt    = {N_REQ{1'b0}};
    idx    = 2'd0;
    valid  = 1'b0;
    cand_s = 2'd0;
    hit_s  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_s = last + 2'(i);
      hit_s  = req[cand_s] & ~valid;
      gnt    = gnt | ({{(N_REQ-1){1'b0}}, hit_s} << cand_s);
      idx    = hit_s ? cand_s : idx;
      valid  = valid | hit_s;
    end
  end

endmodule

// File: rtl/play_sched.sv
// Play scheduler: grants one requester at a time to the shared beat counter.
// Optional feature: define PLAY_PREEMPT_EN to let requester 0 preempt playback.
module play_sched
  import play_pkg::*;
#(
  parameter int BEAT_LEN = DEF_BEAT_LEN,
  parameter int GAP_CYC  = DEF_GAP_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] loop_req,
  input  logic             stop,
  input  logic [7:0]       ibeat,
  output logic             play,
  output logic             loop,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       track,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] abort,
  output logic             busy
);

  localparam logic [7:0] BEAT_END = 8'(BEAT_LEN);
  localparam logic [7:0] GAP_LAST = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

  state_t           state_r;
  logic [1:0]       last_r;
  logic [7:0]       gap_cnt_r;
  logic [N_REQ-1:0] arb_gnt_s;
  logic [1:0]       arb_idx_s;
  logic             arb_valid_s;
  logic             waiters_s;
  logic             loop_s;
  logic             beat_end_s;
`ifdef PLAY_PREEMPT_EN
  logic             req0_prev_r;
  logic             preempt_s;
`endif

  rr_arb4 u_arb (
    .req   (req),
    .last  (last_r),
    .gnt   (arb_gnt_s),
    .idx   (arb_idx_s),
    .valid (arb_valid_s)
  );

  // Looping is only allowed while nobody else is waiting
  always_comb begin
    waiters_s  = |(req & ~grant);
    loop_s     = loop_req[track] & ~waiters_s;
    beat_end_s = (ibeat == BEAT_END);
`ifdef PLAY_PREEMPT_EN
    preempt_s  = req[0] & ~req0_prev_r & (track != 2'd0);
`endif
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      last_r    <= 2'd3;
      gap_cnt_r <= 8'd0;
      grant     <= {N_REQ{1'b0}};
      track     <= 2'd0;
      play      <= 1'b0;
      loop      <= 1'b0;
      done      <= {N_REQ{1'b0}};
      abort     <= {N_REQ{1'b0}};
      busy      <= 1'b0;
`ifdef PLAY_PREEMPT_EN
      req0_prev_r <= 1'b0;
`endif
    end else begin
      play  <= 1'b0;
      done  <= {N_REQ{1'b0}};
      abort <= {N_REQ{1'b0}};
`ifdef PLAY_PREEMPT_EN
      req0_prev_r <= req[0];
`endif
      case (state_r)
        ST_IDLE: begin
          if (arb_valid_s && !stop) begin
            state_r <= ST_START;
            grant   <= arb_gnt_s;
            track   <= arb_idx_s;
            last_r  <= arb_idx_s;
            play    <= 1'b1;
            busy    <= 1'b1;
          end else begin
            grant <= {N_REQ{1'b0}};
            busy  <= 1'b0;
          end
          loop <= 1'b0;
        end
        // The counter still holds its previous value here, so ibeat is ignored
        ST_START: begin
          if (stop) begin
            abort     <= grant;
            state_r   <= ST_GAP;
            grant     <= {N_REQ{1'b0}};
            loop      <= 1'b0;
            gap_cnt_r <= 8'd0;
          end else begin
            state_r <= ST_PLAY;
            loop    <= loop_s;
          end
        end
        ST_PLAY: begin
          if (stop) begin
            abort     <= grant;
            state_r   <= ST_GAP;
            grant     <= {N_REQ{1'b0}};
            loop      <= 1'b0;
            gap_cnt_r <= 8'd0;
`ifdef PLAY_PREEMPT_EN
          end else if (preempt_s) begin
            abort   <= grant;
            state_r <= ST_START;
            grant   <= {{(N_REQ-1){1'b0}}, 1'b1};
            track   <= 2'd0;
            last_r  <= 2'd0;
            play    <= 1'b1;
            loop    <= 1'b0;
`endif
          end else if (!req[track]) begin
            state_r   <= ST_GAP;
            grant     <= {N_REQ{1'b0}};
            loop      <= 1'b0;
            gap_cnt_r <= 8'd0;
          end else if (beat_end_s && !loop_s) begin
            done      <= grant;
            state_r   <= ST_GAP;
            grant     <= {N_REQ{1'b0}};
            loop      <= 1'b0;
            gap_cnt_r <= 8'd0;
          end else begin
            loop <= loop_s;
          end
        end
        ST_GAP: begin
          loop <= 1'b0;
          if (gap_cnt_r >= GAP_LAST) begin
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
            gap_cnt_r <= 8'd0;
          end else begin
            gap_cnt_r <= gap_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          grant     <= {N_REQ{1'b0}};
          loop      <= 1'b0;
          busy      <= 1'b0;
          gap_cnt_r <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_play_sched.sv
// Scoreboard bench for play_sched with a behavioural beat-counter model.
module tb_play_sched;

  localparam int BL = 4;
  localparam int GC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, loop_req;
  logic       stop;
  logic [7:0] ibeat;
  logic       play, loop, busy;
  logic [3:0] grant, done, abort;
  logic [1:0] track;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  play_sched #(.BEAT_LEN(BL), .GAP_CYC(GC)) dut (
    .clk(clk), .rst(rst), .req(req), .loop_req(loop_req), .stop(stop),
    .ibeat(ibeat), .play(play), .loop(loop), .grant(grant), .track(track),
    .done(done), .abort(abort), .busy(busy)
  );

  always #5 clk = ~clk;

  // Beat counter: restarts on play, stops at BL unless looping
  always @(posedge clk or posedge rst) begin
    if (rst) ibeat <= 8'd0;
    else if (play) ibeat <= 8'd0;
    else if (ibeat == 8'(BL)) ibeat <= loop ? 8'd0 : ibeat;
    else ibeat <= ibeat + 8'd1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_take(input logic [7:0] ev);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check_val("sb_unexpected", {24'd0, ev}, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("sb_event", {24'd0, ev}, {24'd0, e});
    end
  endtask

  // Event codes: 1x = play with grant x, 2x = done x, 3x = abort x
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (play) sb_take({4'h1, grant});
      if (done != 4'b0000) sb_take({4'h2, done});
      if (abort != 4'b0000) sb_take({4'h3, abort});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; loop_req = 4'b0000; stop = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Requesters release req once served, until all expected events arrive
  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      req = req & ~(done | abort);
      tick();
      n++;
    end
    req = req & ~(done | abort);
    check_val(tag, exp_q.size(), 32'd0);
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, nd, nw;
    logic [7:0] prev;

    do_reset();
    check_val("rst_grant", grant, 32'd0);
    check_val("rst_track", track, 32'd0);
    check_val("rst_play", play, 32'd0);
    check_val("rst_loop", loop, 32'd0);
    check_val("rst_done", done, 32'd0);
    check_val("rst_abort", abort, 32'd0);
    check_val("rst_busy", busy, 32'd0);

    // Single request, normal completion
    exp_q.push_back(8'h11); exp_q.push_back(8'h21);
    req = 4'b0001;
    tick();
    check_val("a_grant", grant, 32'h1);
    check_val("a_play", play, 32'd1);
    n = 0;
    while (done == 4'b0000 && n < 20) begin tick(); n++; end
    check_val("a_done_lat", n, BL + 2);
    req = 4'b0000;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check_val("a_gap_len", n, GC);
    check_val("a_drain", exp_q.size(), 32'd0);

    // Two held requesters alternate 0,2,0,2
    do_reset();
    exp_q.push_back(8'h11); exp_q.push_back(8'h21);
    exp_q.push_back(8'h14); exp_q.push_back(8'h24);
    exp_q.push_back(8'h11); exp_q.push_back(8'h21);
    exp_q.push_back(8'h14); exp_q.push_back(8'h24);
    req = 4'b0101;
    n = 0; nd = 0;
    while (nd < 4 && n < 200) begin
      tick(); n++;
      if (done != 4'b0000) nd++;
    end
    req = 4'b0000;
    check_val("b_dones", nd, 32'd4);
    drain("b_drain", 20);

    // Looping requester yields when another requester arrives
    exp_q.push_back(8'h12);
    loop_req = 4'b0010; req = 4'b0010;
    n = 0;
    while (!loop && n < 20) begin tick(); n++; end
    check_val("c_loop_on", loop, 32'd1);
    n = 0; nw = 0; prev = ibeat;
    while (nw < 3 && n < 100) begin
      tick(); n++;
      if (prev == 8'd4 && ibeat == 8'd0) nw++;
      prev = ibeat;
    end
    check_val("c_wraps", nw, 32'd3);
    exp_q.push_back(8'h22); exp_q.push_back(8'h18); exp_q.push_back(8'h28);
    req = 4'b1010;
    tick();
    check_val("c_loop_off", loop, 32'd0);
    drain("c_drain", 100);
    loop_req = 4'b0000;

    // Stop mid-beat aborts the owner
    exp_q.push_back(8'h14); exp_q.push_back(8'h34);
    req = 4'b0100;
    n = 0;
    while (!(grant == 4'b0100 && !play && ibeat == 8'd2) && n < 30) begin tick(); n++; end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_val("d_abort", abort, 32'h4);
    check_val("d_no_done", done, 32'd0);
    drain("d_drain", 20);

    // Stop coincident with the final beat: abort wins
    exp_q.push_back(8'h14); exp_q.push_back(8'h34);
    req = 4'b0100;
    n = 0;
    while (!(grant == 4'b0100 && !play && ibeat == 8'd4) && n < 30) begin tick(); n++; end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_val("d2_abort", abort, 32'h4);
    check_val("d2_no_done", done, 32'd0);
    drain("d2_drain", 20);

    // Requester 0 arrives while track 3 plays
    exp_q.push_back(8'h18);
    req = 4'b1000;
    n = 0;
    while (!(grant == 4'b1000 && !play && ibeat == 8'd1) && n < 30) begin tick(); n++; end
`ifdef PLAY_PREEMPT_EN
    exp_q.push_back(8'h38); exp_q.push_back(8'h11); exp_q.push_back(8'h21);
    req = 4'b1001;
    tick();
    check_val("e_pre_track", track, 32'd0);
    check_val("e_pre_play", play, 32'd1);
`else
    exp_q.push_back(8'h28); exp_q.push_back(8'h11); exp_q.push_back(8'h21);
    req = 4'b1001;
    tick();
    check_val("e_keep_track", track, 32'd3);
`endif
    drain("e_drain", 60);

    // Asynchronous reset in the middle of playback
    exp_q.push_back(8'h11);
    req = 4'b0001;
    n = 0;
    while (!(grant == 4'b0001 && !play && ibeat == 8'd2) && n < 30) begin tick(); n++; end
    #2;
    rst = 1'b1;
    #1;
    check_val("f_grant", grant, 32'd0);
    check_val("f_busy", busy, 32'd0);
    check_val("f_play", play, 32'd0);
    check_val("f_loop", loop, 32'd0);
    check_val("f_done", done, 32'd0);
    check_val("f_abort", abort, 32'd0);
    tick(); tick();
    req = 4'b0000;
    rst = 1'b0;
    tick(); tick(); tick();
    check_val("f_idle", busy, 32'd0);
    check_val("f_drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
